mc_control_fsm: RTL

- Multicycle control unit for the ARM-subset core; directly upstream of the datapath.
- Consumes the latched instruction and ALU flags from the datapath.
- Sequences every instruction through a main state machine.
- Drives all datapath mux selects and register enables, plus the memory write strobe.
- Holds the NZCV flags register and gates architectural writes on the condition field.

---
 rtl/mc_control_fsm.sv | 292 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/mc_control_fsm.sv
// ---------------------------------------------------------------------------
// mc_control_fsm
//   Multicycle control unit for the ARM-subset core. Sequences each
//   instruction through the main state machine, drives every datapath
//   select and enable plus the memory write strobe, holds the NZCV flags
//   and gates architectural writes on the condition field.
//
//   Optional feature macro: CTRL_MUL_EN
//     defined   : Op=00, Funct[5:1]=00000, Instr[7:4]=1001 decodes as MUL
//                 (ALUControl=101, S updates N and Z only).
//     undefined : that encoding is an ordinary AND register instruction.
// ---------------------------------------------------------------------------
module mc_control_fsm #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        Instr,
  input  logic [3:0]         ALUFlags,
  output logic               PCWrite,
  output logic               RegWrite,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               AdrSrc,
  output logic [1:0]         RegSrc,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ResultSrc,
  output logic [1:0]         ImmSrc,
  output logic [2:0]         ALUControl,
  output logic [STATE_W-1:0] State
);

  // Main state encoding; any other value of the register falls back to FETCH.
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } state_t;

  // ALU operation codes driven on ALUControl.
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;
`ifdef CTRL_MUL_EN
  localparam logic [2:0] ALU_MUL = 3'b101;
`endif

  // Datapath select encodings.
  localparam logic [1:0] SRCA_REG   = 2'b00;
  localparam logic [1:0] SRCA_PC    = 2'b01;
  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  state_t state_q;
  state_t state_d;

  logic [3:0] flags_q;    // {N, Z, C, V}
  logic       condex_q;   // condition result of the instruction in flight

  // Instruction fields.
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] cmd;
  logic [3:0] rd;
  logic [3:0] cond;

  assign cond  = Instr[31:28];
  assign op    = Instr[27:26];
  assign funct = Instr[25:20];
  assign rd    = Instr[15:12];
  assign cmd   = funct[4:1];

  // Register-number and operand fields are consumed by the datapath only.
  logic unused_instr;
  assign unused_instr = ^{Instr[19:16], Instr[11:0]};

  // Data-processing decode results.
  logic [2:0] dp_alu;
  logic       dp_supported;
  logic       dp_is_cmp;
`ifdef CTRL_MUL_EN
  logic       dp_is_mul;
`endif

  // Decode the data-processing command into an ALU operation.
  // NOTE: every signal written in an always_comb gets a default on entry so
  // no path through the block leaves it unassigned and infers a latch.
  always_comb begin
    dp_alu       = ALU_ADD;
    dp_supported = 1'b1;
    dp_is_cmp    = 1'b0;
`ifdef CTRL_MUL_EN
    dp_is_mul    = 1'b0;
`endif
    unique case (cmd)
      4'b0100: dp_alu = ALU_ADD;
      4'b0010: dp_alu = ALU_SUB;
      4'b0000: dp_alu = ALU_AND;
      4'b1100: dp_alu = ALU_ORR;
      4'b1010: begin
        dp_alu    = ALU_SUB;
        dp_is_cmp = 1'b1;
      end
      default: dp_supported = 1'b0;
    endcase
`ifdef CTRL_MUL_EN
    // MUL hides inside the AND-register space; the multiply signature wins.
    if (funct[5:1] == 5'b00000 && Instr[7:4] == 4'b1001) begin
      dp_alu    = ALU_MUL;
      dp_is_mul = 1'b1;
    end
`endif
  end

  // Condition evaluation against the stored flags (all sixteen codes).
  logic flag_n, flag_z, flag_c, flag_v;
  logic cond_ex;

  assign {flag_n, flag_z, flag_c, flag_v} = flags_q;

  // Evaluate the condition field; NV (1111) never executes.
  always_comb begin
    cond_ex = 1'b0;
    unique case (cond)
      4'b0000: cond_ex = flag_z;
      4'b0001: cond_ex = !flag_z;
      4'b0010: cond_ex = flag_c;
      4'b0011: cond_ex = !flag_c;
      4'b0100: cond_ex = flag_n;
      4'b0101: cond_ex = !flag_n;
      4'b0110: cond_ex = flag_v;
      4'b0111: cond_ex = !flag_v;
      4'b1000: cond_ex = flag_c && !flag_z;
      4'b1001: cond_ex = !flag_c || flag_z;
      4'b1010: cond_ex = (flag_n == flag_v);
      4'b1011: cond_ex = (flag_n != flag_v);
      4'b1100: cond_ex = !flag_z && (flag_n == flag_v);
      4'b1101: cond_ex = flag_z || (flag_n != flag_v);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  // Write-enable qualifiers shared by the flag register and ALUWB outputs.
  logic in_execute;
  logic flag_we;
  logic dp_reg_we;

  assign in_execute = (state_q == S_EXECUTER) || (state_q == S_EXECUTEI);
  assign flag_we    = in_execute && condex_q && dp_supported && (funct[0] || dp_is_cmp);
  assign dp_reg_we  = condex_q && dp_supported && !dp_is_cmp;

  // Main state register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Latch the condition outcome once per instruction, in DECODE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      condex_q <= 1'b0;
    end else if (state_q == S_DECODE) begin
      condex_q <= cond_ex;
    end
  end

  // NZCV register, updated only by executing data-processing instructions.
  // NOTE: the flags are architectural state read in DECODE, so they are
  // cleared by reset rather than left to power-up values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q <= 4'b0000;
    end else if (flag_we) begin
`ifdef CTRL_MUL_EN
      if (dp_is_mul) begin
        flags_q[3:2] <= ALUFlags[3:2];
      end else begin
        flags_q <= ALUFlags;
      end
`else
      flags_q <= ALUFlags;
`endif
    end
  end

  // Next-state selection.
  always_comb begin
    state_d = S_FETCH;
    unique case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        unique case (op)
          2'b01:   state_d = S_MEMADR;
          2'b00:   state_d = funct[5] ? S_EXECUTEI : S_EXECUTER;
          2'b10:   state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:    state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWR:    state_d = S_FETCH;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  // Datapath control outputs as a function of state, instruction and CondEx.
  always_comb begin
    PCWrite    = 1'b0;
    RegWrite   = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = SRCA_REG;
    ALUSrcB    = SRCB_REG;
    ResultSrc  = RES_ALUOUT;
    ALUControl = ALU_ADD;
    ImmSrc     = op;
    RegSrc     = {(op == 2'b01) && !funct[0], (op == 2'b10)};
    unique case (state_q)
      S_FETCH: begin
        IRWrite   = 1'b1;
        PCWrite   = 1'b1;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALU;
      end
      S_DECODE: begin
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALU;
      end
      S_MEMADR: begin
        ALUSrcB = SRCB_IMM;
      end
      S_MEMRD: begin
        AdrSrc = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        RegWrite  = condex_q;
      end
      S_MEMWR: begin
        AdrSrc   = 1'b1;
        MemWrite = condex_q;
      end
      S_EXECUTER: begin
        ALUControl = dp_alu;
      end
      S_EXECUTEI: begin
        ALUSrcB    = SRCB_IMM;
        ALUControl = dp_alu;
      end
      S_ALUWB: begin
        RegWrite = dp_reg_we;
        PCWrite  = dp_reg_we && (rd == 4'd15);
      end
      S_BRANCH: begin
        ALUSrcB   = SRCB_IMM;
        ResultSrc = RES_ALU;
        PCWrite   = condex_q;
      end
      default: ;
    endcase
  end

  assign State = STATE_W'(state_q);

endmodule
